// File: rtl/uart_tx_buffered.sv
// UART 8N1 transmitter fed from a small circular byte FIFO.
// Frames are sent back-to-back while bytes remain queued; tx comes straight from a flop.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int FIFO_AW      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       wr_en,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       empty,
    output logic       overflow
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int BW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [FIFO_AW:0] DEPTH_C  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [BW-1:0]    BAUD_END = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_ovf;

    state_t             r_state;
    logic [BW-1:0]      r_baud;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic               r_tx;
    logic               r_busy;

    logic               w_push;
    logic               w_pop;
    logic               w_baud_end;

    assign full       = (r_count == DEPTH_C);
    assign empty      = (r_count == '0);
    assign overflow   = r_ovf;
    assign tx         = r_tx;
    assign busy       = r_busy;

    assign w_baud_end = (r_baud == BAUD_END);
    assign w_push     = wr_en && !full;
    // Pop from idle, or at the very end of a stop bit so the next start bit follows with no gap.
    assign w_pop      = !empty && ((r_state == S_IDLE) || (r_state == S_STOP && w_baud_end));

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            // A write while full is dropped even if a pop frees a slot on the same edge.
            if (wr_en && full)
                r_ovf <= 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift <= r_mem[r_rptr];
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_baud  <= '0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_tx    <= r_shift[0];
                        r_bit   <= '0;
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                            r_bit   <= r_bit + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= r_mem[r_rptr];
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: queue/frame-timer reference model compared every cycle,
// an independent mid-bit UART decoder as scoreboard, and directed literal checks.
`timescale 1ns/1ps
module tb_uart_tx_buffered;
    localparam int CPB   = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 2 ** AW;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       wr_en;
    logic       tx, busy, full, empty, overflow;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .wr_en(wr_en),
        .tx(tx), .busy(busy), .full(full), .empty(empty), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a byte queue plus "which cycle of which frame" counter.
    logic [7:0] mq[$];
    logic [7:0] exp_tx[$];
    logic [7:0] rx_log[$];
    logic       m_busy = 1'b0;
    int         m_t = 0;
    logic [7:0] m_byte = 8'h00;
    logic       m_ovf = 1'b0;
    logic       m_valid = 1'b0;
    logic       m_rst_now = 1'b0;

    always @(posedge clk) begin
        logic was_full, pop;
        if (reset) begin
            mq.delete();
            exp_tx.delete();
            m_busy = 1'b0; m_t = 0; m_ovf = 1'b0;
            m_valid = 1'b1; m_rst_now = 1'b1;
        end else begin
            m_rst_now = 1'b0;
            was_full = (mq.size() == DEPTH);
            pop = 1'b0;
            if (!m_busy) begin
                if (mq.size() != 0) pop = 1'b1;
            end else if (m_t == FRAME - 1) begin
                if (mq.size() != 0) pop = 1'b1;
                else m_busy = 1'b0;
            end else begin
                m_t++;
            end
            if (pop) begin
                m_byte = mq.pop_front();
                exp_tx.push_back(m_byte);
                m_busy = 1'b1;
                m_t = 0;
            end
            if (wr_en) begin
                if (was_full) m_ovf = 1'b1;
                else mq.push_back(data_in);
            end
        end
    end

    function automatic logic exp_line();
        int k;
        if (!m_busy) return 1'b1;
        k = m_t / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_byte[k-1];
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            chk("tx", tx, exp_line());
            chk("busy", busy, m_busy);
            chk("full", full, mq.size() == DEPTH);
            chk("empty", empty, mq.size() == 0);
            chk("overflow", overflow, m_ovf);
        end
    end

    // Independent receiver: start detect, then sample each bit at its middle.
    logic       dec_active = 1'b0;
    int         dec_cnt = 0;
    logic [7:0] dec_byte = 8'h00;

    always @(negedge clk) begin
        if (m_rst_now || !m_valid) begin
            dec_active = 1'b0;
        end else if (!dec_active) begin
            if (tx === 1'b0) begin
                dec_active = 1'b1;
                dec_cnt = 0;
            end
        end else begin
            dec_cnt++;
            if (dec_cnt == CPB / 2) begin
                chk("rx_start", tx, 1'b0);
            end else if (dec_cnt == CPB / 2 + 9 * CPB) begin
                chk("rx_stop", tx, 1'b1);
                dec_active = 1'b0;
                rx_log.push_back(dec_byte);
                if (exp_tx.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL rx_extra: got %0h expected none", dec_byte);
                end else begin
                    chk("rx_byte", dec_byte, exp_tx.pop_front());
                end
            end else if ((dec_cnt - CPB / 2) % CPB == 0) begin
                dec_byte = {tx, dec_byte[7:1]};
            end
        end
    end

    task automatic put(input logic [7:0] b);
        data_in = b;
        wr_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((m_busy || mq.size() != 0 || dec_active) && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= budget) begin
            n_errors++;
            $display("FAIL wait_idle: got timeout after %0d cycles expected idle", n);
        end
    endtask

    task automatic wait_frame_pos(input int qsz, input int t, input int budget);
        int n = 0;
        while (!(m_busy && mq.size() == qsz && m_t == t) && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= budget) begin
            n_errors++;
            $display("FAIL wait_frame_pos: got timeout expected q=%0d t=%0d", qsz, t);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] pat;
        logic [7:0] e3 [3];
        int base;

        reset = 1'b1; wr_en = 1'b0; data_in = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_ovf", overflow, 1'b0);
        repeat (2) @(negedge clk);

        // Single 0xA5 frame, sampled mid-bit against a hand-written waveform.
        pat = 10'b1101001010;
        put(8'hA5);
        wr_en = 1'b0;
        chk("a5_empty_after_write", empty, 1'b0);
        chk("a5_tx_before_start", tx, 1'b1);
        for (int i = 0; i < 10; i++) begin
            repeat ((i == 0) ? 3 : 4) @(negedge clk);
            chk($sformatf("a5_bit%0d", i), tx, pat[i]);
        end
        @(negedge clk);
        chk("a5_busy_last", busy, 1'b1);
        @(negedge clk);
        chk("a5_busy_done", busy, 1'b0);
        chk("a5_empty_done", empty, 1'b1);
        chk("a5_rx", rx_log[rx_log.size()-1], 8'hA5);

        // Three contiguous frames.
        base = rx_log.size();
        e3[0] = 8'h00; e3[1] = 8'hFF; e3[2] = 8'h3C;
        for (int i = 0; i < 3; i++) put(e3[i]);
        wr_en = 1'b0;
        wait_idle(3 * FRAME + 50);
        chk("b2b_count", rx_log.size() - base, 3);
        for (int i = 0; i < 3; i++) chk($sformatf("b2b_byte%0d", i), rx_log[base+i], e3[i]);

        // Fill to full, overflow, and a write coinciding with a STOP->START pop at count 15.
        base = rx_log.size();
        for (int b = 1; b <= 17; b++) put(8'(b));
        wr_en = 1'b0;
        chk("fill_full", full, 1'b1);
        chk("fill_ovf_clear", overflow, 1'b0);
        put(8'h12);
        wr_en = 1'b0;
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_still_full", full, 1'b1);
        wait_frame_pos(15, FRAME - 1, 3 * FRAME);
        put(8'h55);
        wr_en = 1'b0;
        chk("pop_push_full", full, 1'b0);
        chk("pop_push_empty", empty, 1'b0);
        wait_idle(19 * FRAME);
        chk("fill_count", rx_log.size() - base, 18);
        for (int i = 0; i < 17; i++) chk($sformatf("fill_byte%0d", i), rx_log[base+i], 8'(i + 1));
        chk("fill_byte55", rx_log[base+17], 8'h55);
        chk("ovf_sticky", overflow, 1'b1);

        // Reset 13 cycles into a frame with three bytes queued.
        base = rx_log.size();
        put(8'hC1); put(8'hC2); put(8'hC3); put(8'hC4);
        wr_en = 1'b0;
        wait_frame_pos(3, 12, 2 * FRAME);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_tx", tx, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_empty", empty, 1'b1);
        chk("midrst_ovf", overflow, 1'b0);
        repeat (5 * FRAME) @(negedge clk);
        chk("midrst_no_frames", rx_log.size() - base, 0);

        // Pointer wrap: 40 sequential bytes in bursts of 10.
        base = rx_log.size();
        for (int burst = 0; burst < 4; burst++) begin
            for (int i = 0; i < 10; i++) put(8'(burst * 10 + i));
            wr_en = 1'b0;
            wait_idle(11 * FRAME);
        end
        chk("wrap_count", rx_log.size() - base, 40);
        for (int i = 0; i < 40; i++) chk($sformatf("wrap_byte%0d", i), rx_log[base+i], 8'(i));

        // Random traffic, including overflow pressure and occasional resets.
        for (int c = 0; c < 2500; c++) begin
            wr_en = ($urandom_range(0, 15) == 0);
            data_in = 8'($urandom);
            reset = ($urandom_range(0, 799) == 0);
            @(negedge clk);
        end
        wr_en = 1'b0;
        reset = 1'b0;
        wait_idle((DEPTH + 2) * FRAME);
        chk("scoreboard_drained", exp_tx.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- UART 8N1 transmitter with an internal byte FIFO; drives the board `tx` line out of the I/O manager.
- Producers (processor store path, or loopback from the receive side) push bytes with a single-cycle write strobe.
- The block serialises bytes back-to-back with no software pacing.
- Counterpart of the receive path: one start bit, 8 data bits LSB first, one stop bit, line idles high.

Parameters:
- CLKS_PER_BIT, 10417, clock cycles per UART bit (100 MHz / 9600 baud); must be >= 2.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16 bytes.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  8  byte to enqueue.
- wr_en  input  1  enqueue strobe, sampled each rising edge.
- tx  output  1  serial line, idle high.
- busy  output  1  high while a frame is on the line (START/DATA/STOP).
- full  output  1  FIFO holds 2**FIFO_AW bytes.
- empty  output  1  FIFO holds 0 bytes.
- overflow  output  1  sticky; set when wr_en is asserted while full.

Behaviour:
- Reset values (edge with reset=1):
  - tx=1, busy=0, full=0, empty=1, overflow=0.
  - FIFO pointers and count = 0; state=IDLE; bit and baud counters = 0.
  - Reset mid-frame aborts the frame; tx returns high on that edge and queued bytes are discarded.
- FIFO:
  - Circular buffer; write/read pointers wrap modulo depth.
  - Count is FIFO_AW+1 bits wide. full = (count==depth); empty = (count==0); both registered or derived from registered count.
  - Write accepted iff wr_en && !full.
  - wr_en while full: byte dropped and overflow<=1, even if a pop occurs on the same edge.
  - Simultaneous accepted write and pop: count unchanged, both pointers advance.
- State machine (IDLE, START, DATA, STOP); baud counter counts 0..CLKS_PER_BIT-1.
  - IDLE: tx=1, busy=0. On an edge with !empty: pop the head byte into an 8-bit shift register, tx<=0, busy<=1, baud=0, state<=START.
  - START: hold tx=0 for CLKS_PER_BIT cycles. At baud==CLKS_PER_BIT-1: tx<=shift[0], bit index=0, state<=DATA.
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. At the end of a bit, shift right and increment the index. After bit 7: tx<=1, state<=STOP.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles. At the end, if !empty: pop immediately and go to START with tx<=0 (no idle gap). Otherwise busy<=0, state<=IDLE.
- Timing:
  - Byte written at edge N into an empty FIFO while IDLE: empty=0 after N; pop and start bit at edge N+1.
  - Frame length is exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- tx is driven directly from a flop (no combinational glitches).
- A write during a frame never disturbs the frame in flight.

Test Plan:
- CLKS_PER_BIT=4. Write 0xA5 once from idle -> tx low 1 cycle after the write edge. Sample mid-bit: 0,1,0,1,0,0,1,0,1,1. busy high for 40 cycles, then empty=1, busy=0.
- Write 0x00, 0xFF, 0x3C on consecutive cycles -> three contiguous 40-cycle frames (120 cycles) with no idle bits between stop and next start. Decoded bytes are 0x00, 0xFF, 0x3C in order.
- Hold tx busy, then write 17 bytes 0x01..0x11 (one popped after first write) -> full=1 once 16 bytes are queued. A further write sets overflow=1 and is dropped. All accepted bytes are transmitted in order; overflow stays 1 until reset.
- Write 0x55 at FIFO count 15 on the same edge as a STOP->START pop -> count stays 15, full stays 0, 0x55 is later transmitted.
- Assert reset for 1 cycle 13 cycles into a frame with 3 bytes queued -> tx=1 on the reset edge; busy=0, empty=1, overflow=0; no further start bits.
- Write-pointer wrap: push/transmit 40 sequential bytes in bursts of 10 -> received stream equals 0..39 exactly; no duplicates or losses across the pointer wrap.
